mips_wb_trace: RTL
==================

# mips_wb_trace

Write-back trace capture for the single-cycle `mips` core: it sits directly downstream of the CPU and consumes the per-cycle architectural write events it produces (GRF writes and data-memory stores). Each event becomes a fixed-format record that is buffered in a FIFO and drained over a valid/ready stream. The stream feeds the simulation checker or a debug serializer, so that checking no longer depends on `$display` output inside the core.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; a power of two, at least 2.
- `CNT_W`, 16: width of the drop counter.

Ports:
- `clk` input 1: the single clock; every edge used is rising.
- `reset` input 1: synchronous, active-low; state is cleared on a rising `clk` edge with `reset==0`.
- `pc` input 32: PC of the instruction executing this cycle.
- `grf_we` input 1: GRF write occurs this cycle.
- `grf_addr` input 5: GRF destination register.
- `grf_wd` input 32: GRF write data.
- `dm_we` input 1: data-memory store occurs this cycle.
- `dm_addr` input 32: byte address of the store.
- `dm_wd` input 32: store data.
- `rec_valid` output 1: a record is present at the FIFO head.
- `rec_data` output 97: head record, laid out as `{kind, pc, addr, data}`.
  - `kind` is 0 for GRF and 1 for DM.
  - For GRF records, `addr` is `grf_addr` zero-extended to 32 bits.
- `rec_ready` input 1: consumer accepts the head record.
- `level` output clog2(DEPTH)+1: current occupancy.
- `overflow` output 1: sticky flag, set when any event has been dropped.
- `drop_cnt` output CNT_W: number of dropped events, saturating.

## Operation
- Inputs are sampled on each rising edge.
- Push count per cycle is `grf_we + dm_we`, so 0, 1 or 2 records.
- When both events occur in one cycle:
  - The GRF record is written first, the DM record second.
  - Consumer order follows the same sequence.
- Free-space check uses occupancy before this cycle's pop: accept iff `DEPTH - level >= push count`.
- Insufficient space:
  - All of that cycle's events are dropped; no partial push happens.
  - `overflow` is set to 1.
  - `drop_cnt` increases by the number of dropped events and saturates at all-ones.
- A pop occurs when `rec_valid && rec_ready`. Push and pop in the same cycle are both honoured.
- Level update: `level_next = level + pushes - pop`.
- Pointers are `clog2(DEPTH)` bits wide and wrap modulo DEPTH.
- `rec_data` behaviour:
  - It is the head entry, read combinationally from the registered read pointer.
  - It is 0 when empty.
  - It holds stable while `rec_valid && !rec_ready`.
- Reset values: `rec_valid` 0, `rec_data` 0, `level` 0, `overflow` 0, `drop_cnt` 0, both pointers 0.
- Reset mid-operation flushes all buffered records. Events presented in the reset cycle are ignored.
- `overflow` and `drop_cnt` clear only on reset.

## Timing
- Latency: an event sampled at edge N makes `rec_valid` high right after edge N, so it is consumable in cycle N+1.
- Throughput: up to 2 pushes and 1 pop per cycle.
  - A continuously asserted `rec_ready` sustains one record per cycle.
- Full FIFO (`level==DEPTH`) with `rec_ready==1` and one event: the event is dropped, because the check is pre-pop. This is intentional and conservative.
- Empty FIFO with a push and `rec_ready==1` in the same cycle: no pop, since `rec_valid` was 0. The record appears the next cycle.
- `level==DEPTH-1` with a double event: both events are dropped and `drop_cnt` increases by 2.

## Configuration
- `MIPS_TRACE_R0_FILTER_EN`
  - Defined: GRF events with `grf_addr==0` are discarded before the push count is formed. They are neither buffered nor counted as drops.
  - Undefined: writes to `$0` are recorded like any other GRF write.

## Structure
- Shared package `mips_trace_pkg` holds:
  - record width 97;
  - field offsets (`KIND` bit 96, `PC` 95:64, `ADDR` 63:32, `DATA` 31:0);
  - kind constants `TRACE_GRF=0` and `TRACE_DM=1`.
- One sub-module, `trace_fifo`:
  - dual-write, single-read FIFO with DEPTH entries;
  - ports for push0/push1 enables and data, pop, head, and level.
- The top level does event formatting, the space check, the optional filter, and the overflow/drop logic.

## Test plan
- Reset, then one GRF event with `pc=0x3000`, `grf_addr=8`, `grf_wd=0x1234`, and `rec_ready=1`:
  - `rec_valid` is high one cycle later;
  - `rec_data={0,0x00003000,0x00000008,0x00001234}`;
  - `level` returns to 0 after the pop.
- Simultaneous GRF (`$9`, `0xAA`) and DM (`0x10`, `0xBB`) events at `pc=0x3004`:
  - two records, GRF then DM;
  - `level` reaches 2 with `rec_ready=0`.
- Hold `rec_ready=0` and issue 17 single events with DEPTH=16:
  - `level=16`, `overflow=1`, `drop_cnt=1`;
  - draining returns the first 16 records in order.
- Wrap-around: push and pop continuously for 40 cycles with incrementing data; the output sequence matches the input exactly, with no gaps.
- Reset asserted (`reset=0`) with `level=5`: next cycle `level=0`, `rec_valid=0`, `overflow=0`, `drop_cnt=0`.
- GRF write to `$0` with data `0x5`:
  - with `MIPS_TRACE_R0_FILTER_EN` defined, no record and `drop_cnt` unchanged;
  - without it, one record with `addr=0`.

Source files
------------

// File: rtl/mips_trace_pkg.sv
// Shared types and constants for the write-back trace capture block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mips_trace_pkg;

    // Record layout: kind is the MSB, then pc, addr and data.
    localparam int REC_W    = 97;
    localparam int KIND_BIT = 96;
    localparam int PC_MSB   = 95;
    localparam int PC_LSB   = 64;
    localparam int ADDR_MSB = 63;
    localparam int ADDR_LSB = 32;
    localparam int DATA_MSB = 31;
    localparam int DATA_LSB = 0;

    localparam logic TRACE_GRF = 1'b0;
    localparam logic TRACE_DM  = 1'b1;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    // Builds one record; field placement matches the offsets above.
    function automatic rec_t make_rec(input logic kind, input logic [31:0] pc,
                                      input logic [31:0] addr, input logic [31:0] data);
        rec_t r;
        r.kind = kind;
        r.pc   = pc;
        r.addr = addr;
        r.data = data;
        return r;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Dual-write, single-read record FIFO; push0 lands before push1 in queue order.
// Latency: a record written at edge N is visible at head_o right after edge N.
// Backpressure: none internally; caller must only push when space exists and pop when vld_o.
module trace_fifo
    import mips_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push0_i,
    input  rec_t             push0_dat_i,
    input  logic             push1_i,
    input  rec_t             push1_dat_i,
    input  logic             pop_i,
    output rec_t             head_o,
    output logic             vld_o,
    output logic [LVL_W-1:0] level_o
);

    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d, wr_nx;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    rec_t             mem_q [DEPTH];

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_nx = wr_q + PTR_W'(1);
        wr_d  = wr_q + PTR_W'(push0_i) + PTR_W'(push1_i);
        rd_d  = rd_q + PTR_W'(pop_i);
        lvl_d = lvl_q + LVL_W'(push0_i) + LVL_W'(push1_i) - LVL_W'(pop_i);
    end

    // Pointer/occupancy registers; reset flushes everything buffered.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
        end
    end

    // Storage; contents need no reset because the head is masked when empty.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && push0_i) mem_q[wr_q]  <= push0_dat_i;
        if (rst_n_i && push1_i) mem_q[wr_nx] <= push1_dat_i;
    end

    assign vld_o   = (lvl_q != '0);
    assign head_o  = vld_o ? mem_q[rd_q] : '0;
    assign level_o = lvl_q;

endmodule

// File: rtl/mips_wb_trace.sv
// Formats GRF/DM write events into trace records, buffers them and streams them out.
// Latency: event sampled at edge N is valid right after edge N; 1 record/cycle out.
// Backpressure: rec_ready stalls the head; when space is short all of a cycle's events are dropped and counted.
// Optional: define MIPS_TRACE_R0_FILTER_EN to discard GRF writes to register 0.
module mips_wb_trace
    import mips_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc,
    input  logic             grf_we,
    input  logic [4:0]       grf_addr,
    input  logic [31:0]      grf_wd,
    input  logic             dm_we,
    input  logic [31:0]      dm_addr,
    input  logic [31:0]      dm_wd,
    output logic             rec_valid,
    output logic [REC_W-1:0] rec_data,
    input  logic             rec_ready,
    output logic [LVL_W-1:0] level,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt
);

    logic             grf_ev;
    logic [1:0]       n_push;
    logic [LVL_W-1:0] free_slots;
    logic             fits;
    logic             drop;
    logic             push0, push1, pop;
    rec_t             grf_rec, dm_rec, push0_dat, head;
    logic [CNT_W:0]   drop_sum;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    // Event qualification, pre-pop space check and record steering.
    always_comb begin
        grf_ev = grf_we;
`ifdef MIPS_TRACE_R0_FILTER_EN
        grf_ev = grf_we && (grf_addr != 5'd0);
`endif
        n_push     = {1'b0, grf_ev} + {1'b0, dm_we};
        free_slots = LVL_W'(DEPTH) - level;
        fits       = (free_slots >= LVL_W'(n_push));
        drop       = !fits;
        grf_rec    = make_rec(TRACE_GRF, pc, {27'd0, grf_addr}, grf_wd);
        dm_rec     = make_rec(TRACE_DM, pc, dm_addr, dm_wd);
        // A lone DM event still goes through push0 so it takes the next slot.
        push0      = fits && (grf_ev || dm_we);
        push0_dat  = grf_ev ? grf_rec : dm_rec;
        push1      = fits && grf_ev && dm_we;
        pop        = rec_valid && rec_ready;
    end

    // Sticky overflow and saturating drop counter next-state.
    always_comb begin
        drop_sum   = {1'b0, drop_q} + (CNT_W+1)'(n_push);
        drop_d     = drop_q;
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
            drop_d     = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end

    // Drop status registers; cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk),
        .rst_n_i     (reset),
        .push0_i     (push0),
        .push0_dat_i (push0_dat),
        .push1_i     (push1),
        .push1_dat_i (dm_rec),
        .pop_i       (pop),
        .head_o      (head),
        .vld_o       (rec_valid),
        .level_o     (level)
    );

    assign rec_data = head;
    assign overflow = overflow_q;
    assign drop_cnt = drop_q;

endmodule
